// File: rtl/tur_pkg.sv
// rtl/tur_pkg.sv - shared state enum, point-code width and cell point function for the grid scoring game
package tur_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } tur_state_t;

  localparam int PT_W = 2;

  // Centre is worth 3, edge-midpoints 2, corners 1, row/column 0 nothing.
  function automatic logic [PT_W-1:0] tur_points(input logic [1:0] x, input logic [1:0] y);
    logic [PT_W-1:0] p;
    if (x == 2'd0 || y == 2'd0)      p = 2'd0;
    else if (x == 2'd2 && y == 2'd2) p = 2'd3;
    else if (x == 2'd2 || y == 2'd2) p = 2'd2;
    else                             p = 2'd1;
    return p;
  endfunction

endpackage

// File: rtl/tur_puan.sv
// rtl/tur_puan.sv - combinational (x,y) cell to point-code lookup
module tur_puan
  import tur_pkg::*;
(
  input  logic [1:0]      x,
  input  logic [1:0]      y,
  output logic [PT_W-1:0] pt
);

  // Pure table lookup, no state.
  always_comb begin
    pt = tur_points(x, y);
  end

endmodule

// File: rtl/tur_oyun.sv
// rtl/tur_oyun.sv - turn-based grid scoring game controller; optional claimed-cell lock via TUR_CELL_LOCK_EN
module tur_oyun
  import tur_pkg::*;
#(
  parameter int NP         = 2,
  parameter int SW         = 6,
  parameter int THRESH     = 5,
  parameter int MAX_ROUNDS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mv_valid,
  output logic                  mv_ready,
  input  logic [1:0]            mv_x,
  input  logic [1:0]            mv_y,
  output logic                  mv_err,
  output logic [$clog2(NP)-1:0] cur_player,
  output logic [7:0]            round,
  output logic [NP*SW-1:0]      scores,
  output logic                  done,
  output logic [$clog2(NP)-1:0] winner,
  output logic                  winner_valid
);

  localparam int PW = $clog2(NP);

  tur_state_t      state, state_nxt;
  logic [PT_W-1:0] pt;
  logic [SW-1:0]   cur_score;
  logic [SW-1:0]   new_score;
  logic [SW:0]     sum;
  logic            accept;
  logic            hit;
  logic            wrap;
  logic            round_end;
  logic            claimed;
  logic            full;
  logic            restart;

`ifdef TUR_CELL_LOCK_EN
  logic [15:0] mask;
  logic [3:0]  cell;
  logic        reject;
`endif

  tur_puan u_puan (
    .x  (mv_x),
    .y  (mv_y),
    .pt (pt)
  );

  // Move evaluation: saturating score update, threshold, round-limit and full-board detection.
  always_comb begin
    cur_score = scores[cur_player*SW +: SW];
    sum       = {1'b0, cur_score} + {{(SW+1-PT_W){1'b0}}, pt};
    new_score = sum[SW] ? {SW{1'b1}} : sum[SW-1:0];
    hit       = new_score >= SW'(THRESH);
    wrap      = cur_player == PW'(NP-1);
    round_end = wrap && ((round + 8'd1) == 8'(MAX_ROUNDS));
    restart   = start && (state == IDLE || state == DONE);
`ifdef TUR_CELL_LOCK_EN
    cell      = {mv_x, mv_y};
    claimed   = mask[cell];
    full      = &(mask | (16'd1 << cell));
    reject    = (state == PLAY) && mv_valid && claimed;
`else
    claimed   = 1'b0;
    full      = 1'b0;
`endif
    accept    = (state == PLAY) && mv_valid && !claimed;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: threshold, round limit and full board all end the game.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PLAY;
      PLAY:    if (accept && (hit || round_end || full)) state_nxt = DONE;
      DONE:    if (start) state_nxt = PLAY;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state register only, so mv_ready never depends on mv_valid.
  always_comb begin
    mv_ready = (state == PLAY);
    done     = (state == DONE);
  end

  // Game datapath: scores, turn, round, winner and the claimed-cell mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scores       <= '0;
      cur_player   <= '0;
      round        <= '0;
      winner       <= '0;
      winner_valid <= 1'b0;
`ifdef TUR_CELL_LOCK_EN
      mask         <= '0;
      mv_err       <= 1'b0;
`endif
    end else begin
`ifdef TUR_CELL_LOCK_EN
      mv_err <= reject;
`endif
      if (restart) begin
        scores       <= '0;
        cur_player   <= '0;
        round        <= '0;
        winner       <= '0;
        winner_valid <= 1'b0;
`ifdef TUR_CELL_LOCK_EN
        mask         <= '0;
`endif
      end else if (accept) begin
        scores[cur_player*SW +: SW] <= new_score;
`ifdef TUR_CELL_LOCK_EN
        mask[cell] <= 1'b1;
`endif
        if (hit) begin
          winner       <= cur_player;
          winner_valid <= 1'b1;
        end else begin
          cur_player <= wrap ? '0 : cur_player + 1'b1;
          if (wrap) round <= round + 8'd1;
        end
      end
    end
  end

`ifndef TUR_CELL_LOCK_EN
  assign mv_err = 1'b0;
`endif

endmodule
